// File: rtl/eu_iqueue_banked_pkg.sv
// Shared types for the banked per-exec-unit instruction queue.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package eu_iqueue_banked_pkg;

    localparam int LOG2_NUM_EXEC_UNITS = 2;
    localparam int IQ_LOG2_NUM_BANKS   = 2;

    // One queued instruction as carried on the dispatch bus.
    typedef struct packed {
        logic [7:0] op;
        logic [7:0] tag;
    } type_iqueue_entry;

    // Bank selector for the default bank count; wider configurations size their own pointers.
    typedef logic [IQ_LOG2_NUM_BANKS-1:0] iq_bank_ptr_t;

    // Smaller of two unsigned values.
    function automatic int unsigned iq_min(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/eu_iqueue_banked_if.sv
// Dispatch/issue bundle between front end, instruction queue and exec unit.
// Latency: n/a (wiring only).
// Backpressure: disp_ready_o gates whole dispatch batches; issue_count_i reports consumption.
interface eu_iqueue_banked_if
    import eu_iqueue_banked_pkg::*;
#(
    parameter int NUM_DISPATCH = 4,
    parameter int ISSUE_WIDTH  = 2,
    parameter int CAPACITY     = 16
);
    localparam int COUNT_W = $clog2(CAPACITY + 1);
    localparam int ICNT_W  = $clog2(ISSUE_WIDTH + 1);

    logic                                                flush_i;
    type_iqueue_entry [NUM_DISPATCH-1:0]                 disp_entry_i;
    logic [NUM_DISPATCH-1:0]                             disp_valid_i;
    logic [NUM_DISPATCH-1:0][LOG2_NUM_EXEC_UNITS-1:0]    disp_euidx_i;
    logic                                                disp_ready_o;
    type_iqueue_entry [ISSUE_WIDTH-1:0]                  issue_entry_o;
    logic [ISSUE_WIDTH-1:0]                              issue_valid_o;
    logic [ICNT_W-1:0]                                   issue_count_i;
    logic [COUNT_W-1:0]                                  count_o;

    // Front end plus exec unit side.
    modport master (
        output flush_i, disp_entry_i, disp_valid_i, disp_euidx_i, issue_count_i,
        input  disp_ready_o, issue_entry_o, issue_valid_o, count_o
    );

    // Queue side.
    modport slave (
        input  flush_i, disp_entry_i, disp_valid_i, disp_euidx_i, issue_count_i,
        output disp_ready_o, issue_entry_o, issue_valid_o, count_o
    );

endinterface

// File: rtl/eu_iqueue_banked_bank.sv
// One bank of the instruction queue: single-write/single-pop circular FIFO.
// Latency: written entry becomes head the cycle after the write; head is combinational.
// Backpressure: writes while full and pops while empty are ignored; clear wins over both.
module eu_iq_bank
    import eu_iqueue_banked_pkg::*;
#(
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_vld,
    input  type_iqueue_entry      wr_dat,
    input  logic                  pop,
    output type_iqueue_entry      head,
    output logic                  empty,
    output logic                  full,
    output logic [LOG2_DEPTH:0]   count
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int PW    = LOG2_DEPTH + 1;

    if (LOG2_DEPTH < 1) begin : g_bad_depth
        $error("eu_iq_bank needs at least two entries");
    end

    type_iqueue_entry  mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_pop;

    // The extra pointer bit tells a full bank from an empty one when the slot indices match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[LOG2_DEPTH] != rd_ptr[LOG2_DEPTH]) &&
                    (wr_ptr[LOG2_DEPTH-1:0] == rd_ptr[LOG2_DEPTH-1:0]);
    assign do_wr  = wr_vld & ~full & ~clear;
    assign do_pop = pop & ~empty & ~clear;
    assign head   = mem[rd_ptr[LOG2_DEPTH-1:0]];

    // Storage is deliberately not reset; only pointers define what is live.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[LOG2_DEPTH-1:0]] <= wr_dat;
        end
    end

    // Pointer and occupancy update; clear drops everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_wr, do_pop})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/eu_iqueue_banked.sv
// Per-exec-unit instruction queue: compacts relevant dispatch lanes into round-robin banks, issues up to W in order.
// Latency: accepted entry visible on issue lanes the next cycle; issue outputs are combinational from bank heads.
// Backpressure: all-or-nothing dispatch, disp_ready_o low if any targeted bank is full at start of cycle.
module eu_iqueue_banked
    import eu_iqueue_banked_pkg::*;
#(
    parameter int                             LOG2_NUM_BANKS  = IQ_LOG2_NUM_BANKS,
    parameter int                             LOG2_BANK_DEPTH = 2,
    parameter int                             NUM_DISPATCH    = 4,
    parameter int                             ISSUE_WIDTH     = 2,
    parameter logic [LOG2_NUM_EXEC_UNITS-1:0] EU_IDX          = '0
) (
    input logic               clk,
    input logic               reset,
    eu_iqueue_banked_if.slave bus
);
    localparam int NUM_BANKS  = 1 << LOG2_NUM_BANKS;
    localparam int BANK_DEPTH = 1 << LOG2_BANK_DEPTH;
    localparam int CAPACITY   = NUM_BANKS * BANK_DEPTH;
    localparam int COUNT_W    = $clog2(CAPACITY + 1);
    localparam int ICNT_W     = $clog2(ISSUE_WIDTH + 1);
    localparam int RCNT_W     = $clog2(NUM_DISPATCH + 1);
    localparam int BCNT_W     = LOG2_BANK_DEPTH + 1;

    if (NUM_DISPATCH > NUM_BANKS) begin : g_bad_dispatch
        $error("NUM_DISPATCH must not exceed the number of banks");
    end
    if (ISSUE_WIDTH < 1 || ISSUE_WIDTH > NUM_BANKS) begin : g_bad_issue
        $error("ISSUE_WIDTH must be between 1 and the number of banks");
    end

    logic [LOG2_NUM_BANKS-1:0]                   wr_ptr;
    logic [LOG2_NUM_BANKS-1:0]                   rd_ptr;
    logic [COUNT_W-1:0]                          count_q;

    logic [NUM_DISPATCH-1:0]                     relevant;
    logic [NUM_DISPATCH-1:0][RCNT_W-1:0]         lane_rank;
    logic [RCNT_W-1:0]                           num_relevant;
    logic                                        accept;

    logic [NUM_BANKS-1:0]                        bank_target;
    logic [NUM_BANKS-1:0]                        bank_wr_vld;
    type_iqueue_entry [NUM_BANKS-1:0]            bank_wr_dat;
    logic [NUM_BANKS-1:0]                        bank_pop;
    type_iqueue_entry [NUM_BANKS-1:0]            bank_head;
    logic [NUM_BANKS-1:0]                        bank_empty;
    logic [NUM_BANKS-1:0]                        bank_full;
    logic [NUM_BANKS-1:0][BCNT_W-1:0]            bank_count;

    logic [ICNT_W-1:0]                           avail;
    logic [ICNT_W-1:0]                           consume;
    logic [ISSUE_WIDTH-1:0]                      lane_empty;
    logic [COUNT_W-1:0]                          occ_sum;

    // Rank each relevant lane among the relevant lanes below it; gaps take no bank.
    always_comb begin
        logic [RCNT_W-1:0] acc;
        acc       = '0;
        relevant  = '0;
        lane_rank = '0;
        for (int l = 0; l < NUM_DISPATCH; l++) begin
            relevant[l]  = bus.disp_valid_i[l] && (bus.disp_euidx_i[l] == EU_IDX);
            lane_rank[l] = acc;
            if (relevant[l]) begin
                acc = acc + RCNT_W'(1);
            end
        end
        num_relevant = acc;
    end

    // Rotate relevant lanes onto banks starting at wr_ptr; N <= B keeps every target distinct.
    always_comb begin
        logic [LOG2_NUM_BANKS-1:0] tgt;
        tgt         = '0;
        bank_target = '0;
        bank_wr_dat = '0;
        for (int l = 0; l < NUM_DISPATCH; l++) begin
            if (relevant[l]) begin
                tgt              = wr_ptr + LOG2_NUM_BANKS'(lane_rank[l]);
                bank_target[tgt] = 1'b1;
                bank_wr_dat[tgt] = bus.disp_entry_i[l];
            end
        end
    end

    // Start-of-cycle fullness only: a slot freed by this cycle's pop cannot be refilled yet.
    assign bus.disp_ready_o = ~|(bank_target & bank_full);
    assign accept           = bus.disp_ready_o & ~bus.flush_i;
    assign bank_wr_vld      = bank_target & {NUM_BANKS{accept}};

    // Round-robin writes put global program order at banks rd_ptr, rd_ptr+1, ...
    always_comb begin
        logic [LOG2_NUM_BANKS-1:0] sel;
        sel               = '0;
        bus.issue_entry_o = '0;
        bus.issue_valid_o = '0;
        lane_empty        = '0;
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            sel                  = rd_ptr + LOG2_NUM_BANKS'(j);
            bus.issue_entry_o[j] = bank_head[sel];
            bus.issue_valid_o[j] = (count_q > COUNT_W'(j));
            lane_empty[j]        = bank_empty[sel];
        end
    end

    // An over-large issue count is clamped to the lanes actually shown valid.
    assign avail   = ICNT_W'(iq_min(32'(count_q), ISSUE_WIDTH));
    assign consume = (bus.issue_count_i > avail) ? avail : bus.issue_count_i;

    // Pop the heads of the first `consume` banks counted from rd_ptr.
    always_comb begin
        logic [LOG2_NUM_BANKS-1:0] offset;
        offset   = '0;
        bank_pop = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            offset      = LOG2_NUM_BANKS'(b) - rd_ptr;
            bank_pop[b] = ~bus.flush_i && (32'(offset) < 32'(consume));
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        eu_iq_bank #(
            .LOG2_DEPTH (LOG2_BANK_DEPTH)
        ) u_bank (
            .clk    (clk),
            .reset  (reset),
            .clear  (bus.flush_i),
            .wr_vld (bank_wr_vld[b]),
            .wr_dat (bank_wr_dat[b]),
            .pop    (bank_pop[b]),
            .head   (bank_head[b]),
            .empty  (bank_empty[b]),
            .full   (bank_full[b]),
            .count  (bank_count[b])
        );
    end

    // Bank pointers and total occupancy; flush returns everything to the origin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + LOG2_NUM_BANKS'(num_relevant);
            end
            rd_ptr  <= rd_ptr + LOG2_NUM_BANKS'(consume);
            count_q <= count_q + (accept ? COUNT_W'(num_relevant) : COUNT_W'(0))
                               - COUNT_W'(consume);
        end
    end

    assign bus.count_o = count_q;

    // Sum of per-bank occupancies, which must always track the registered total.
    always_comb begin
        occ_sum = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            occ_sum = occ_sum + COUNT_W'(bank_count[b]);
        end
    end

    // Consumer protocol and internal consistency checks.
    always @(posedge clk) begin
        if (!reset) begin
            assert (bus.issue_count_i <= avail)
                else $warning("issue_count_i exceeds valid issue lanes; clamped");
            assert (occ_sum == count_q)
                else $error("bank occupancy sum disagrees with count");
            assert ((bus.issue_valid_o & lane_empty) == '0)
                else $error("valid issue lane points at an empty bank");
        end
    end

endmodule

// File: tb/tb_eu_iqueue_banked.sv
// Directed bench for eu_iqueue_banked with a scoreboard of expected issue order.
// Stimulus pushes accepted entries into exp_q; a negedge monitor pops and compares consumed lanes.
// Occupancy, ready and valid outputs are checked against hand-computed constants.
module tb_eu_iqueue_banked;
    import eu_iqueue_banked_pkg::*;

    localparam int ND = 4;
    localparam int IW = 2;
    localparam logic [LOG2_NUM_EXEC_UNITS-1:0] EU = '0;

    logic clk;
    logic reset;

    eu_iqueue_banked_if #(.NUM_DISPATCH(ND), .ISSUE_WIDTH(IW), .CAPACITY(16)) bus ();

    eu_iqueue_banked #(
        .LOG2_NUM_BANKS  (2),
        .LOG2_BANK_DEPTH (2),
        .NUM_DISPATCH    (ND),
        .ISSUE_WIDTH     (IW),
        .EU_IDX          (EU)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    type_iqueue_entry exp_q [$];
    int               n_checks = 0;
    int               n_pass   = 0;
    logic [7:0]       next_tag = 8'h10;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush_i       = 1'b0;
        bus.disp_valid_i  = '0;
        bus.issue_count_i = '0;
    endtask

    // Drive all lanes with fresh tags; eus holds lane l's EU index in bits [2l+1:2l].
    task automatic drive_disp(input logic [3:0] v, input logic [7:0] eus, input bit expect_acc);
        type_iqueue_entry e;
        for (int l = 0; l < ND; l++) begin
            e.tag    = next_tag;
            e.op     = next_tag ^ 8'hA5;
            next_tag = next_tag + 8'd1;
            bus.disp_entry_i[l] = e;
            bus.disp_euidx_i[l] = eus[2*l +: 2];
            if (expect_acc && v[l] && (eus[2*l +: 2] == EU)) exp_q.push_back(e);
        end
        bus.disp_valid_i = v;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        idle();
        while (bus.count_o != '0 && guard < 64) begin
            bus.issue_count_i = (bus.count_o >= 5'd2) ? 2'd2 : 2'd1;
            cyc();
            guard++;
        end
        bus.issue_count_i = '0;
        check({name, "_drained"}, 32'(bus.count_o), 0);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 0);
    endtask

    // Monitor: every lane the exec unit consumes must be the next expected entry.
    initial begin
        type_iqueue_entry e;
        forever begin
            @(negedge clk);
            if (!reset && !bus.flush_i) begin
                for (int j = 0; j < IW; j++) begin
                    if (j < int'(bus.issue_count_i) && bus.issue_valid_o[j]) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL sb_lane%0d: got tag %0h required no entry", j,
                                     bus.issue_entry_o[j].tag);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus.issue_entry_o[j] === e) n_pass++;
                            else $display("FAIL sb_lane%0d: got tag %0h op %0h required tag %0h op %0h",
                                          j, bus.issue_entry_o[j].tag, bus.issue_entry_o[j].op,
                                          e.tag, e.op);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bus.disp_entry_i = '0;
        bus.disp_euidx_i = '0;
        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;

        // Reset state and idle.
        check("rst_count", 32'(bus.count_o), 0);
        check("rst_issue_valid", 32'(bus.issue_valid_o), 0);
        check("rst_disp_ready", 32'(bus.disp_ready_o), 1);

        // Lanes 0,2,3 target this unit, lane 1 does not.
        drive_disp(4'b1111, 8'b00_00_01_00, 1'b1);
        #1 check("t2_ready", 32'(bus.disp_ready_o), 1);
        cyc();
        idle();
        #1;
        check("t2_count", 32'(bus.count_o), 3);
        check("t2_valid", 32'(bus.issue_valid_o), 2'b11);
        check("t2_lane0_tag", 32'(bus.issue_entry_o[0].tag), 32'h10);
        check("t2_lane1_tag", 32'(bus.issue_entry_o[1].tag), 32'h12);
        drain("t2");

        // Fill to capacity, then a full bank rejects even while it pops.
        for (int i = 0; i < 4; i++) begin
            drive_disp(4'b1111, 8'h00, 1'b1);
            cyc();
        end
        idle();
        #1 check("t3_full_count", 32'(bus.count_o), 16);
        drive_disp(4'b0001, 8'h00, 1'b0);
        #1 check("t3_reject", 32'(bus.disp_ready_o), 0);
        cyc();
        check("t3_hold_count", 32'(bus.count_o), 16);
        drive_disp(4'b0001, 8'h00, 1'b0);
        bus.issue_count_i = 2'd2;
        #1 check("t3_reject_while_pop", 32'(bus.disp_ready_o), 0);
        cyc();
        bus.issue_count_i = '0;
        check("t3_after_pop_count", 32'(bus.count_o), 14);
        drive_disp(4'b0001, 8'h00, 1'b1);
        #1 check("t3_accept_retry", 32'(bus.disp_ready_o), 1);
        cyc();
        idle();
        #1 check("t3_retry_count", 32'(bus.count_o), 15);
        drain("t3");

        // Batches of 3 against 2 issues per cycle wrap both bank pointers.
        for (int i = 0; i < 5; i++) begin
            drive_disp(4'b0111, 8'h00, 1'b1);
            bus.issue_count_i = (i == 0) ? 2'd0 : 2'd2;
            #1 check("t4_ready", 32'(bus.disp_ready_o), 1);
            cyc();
        end
        idle();
        #1 check("t4_count", 32'(bus.count_o), 7);

        // Flush with a relevant dispatch in the same cycle.
        drive_disp(4'b0001, 8'h00, 1'b0);
        bus.flush_i = 1'b1;
        exp_q.delete();
        #1 check("t5_ready_preflush", 32'(bus.disp_ready_o), 1);
        cyc();
        idle();
        #1;
        check("t5_count", 32'(bus.count_o), 0);
        check("t5_valid", 32'(bus.issue_valid_o), 0);
        cyc();
        check("t5_nothing_written", 32'(bus.count_o), 0);
        drive_disp(4'b0011, 8'h00, 1'b1);
        cyc();
        idle();
        #1;
        check("t5_refill_count", 32'(bus.count_o), 2);
        check("t5_refill_valid", 32'(bus.issue_valid_o), 2'b11);

        // Over-large issue count with one valid lane is clamped to one pop.
        bus.issue_count_i = 2'd1;
        cyc();
        check("t6_one_left", 32'(bus.count_o), 1);
        bus.issue_count_i = 2'd2;
        #1 check("t6_one_valid", 32'(bus.issue_valid_o), 2'b01);
        cyc();
        bus.issue_count_i = '0;
        check("t6_clamp_count", 32'(bus.count_o), 0);

        // Asynchronous reset in the middle of a dispatch cycle.
        drive_disp(4'b0111, 8'h00, 1'b1);
        cyc();
        drive_disp(4'b1111, 8'h00, 1'b0);
        #2;
        check("t6_pre_reset_count", 32'(bus.count_o), 3);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("t6_async_count", 32'(bus.count_o), 0);
        check("t6_async_valid", 32'(bus.issue_valid_o), 0);
        check("t6_async_ready", 32'(bus.disp_ready_o), 1);
        @(posedge clk);
        #1 reset = 1'b0;
        idle();
        cyc();
        check("t6_post_reset_count", 32'(bus.count_o), 0);

        // Gapped lanes after reset: only lanes 2 and 3 target this unit.
        drive_disp(4'b1110, 8'b00_00_11_00, 1'b1);
        cyc();
        idle();
        #1 check("t6_gap_count", 32'(bus.count_o), 2);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
